song_sequencer: RTL and testbench

Parametrised note sequencer that replaces fixed, free-running song ROM addressing with a controlled player. It walks an external synchronous note ROM (8-bit notes, 255 = rest, 1 = end-of-song), holds each step for a programmable number of clocks, and drives note, gate and note-on strobe to the tone generator. It adds features the plain ROM lacks: start/stop control, loop mode, runtime tempo, and gate articulation so repeated notes re-trigger.

---
 rtl/song_pkg.sv | 6 +
 rtl/song_sequencer_if.sv | 19 +
 rtl/song_sequencer_step_timer.sv | 26 ++
 rtl/song_sequencer.sv | 85 ++++++++
 tb/tb_song_sequencer.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/song_pkg.sv
// song_pkg: shared note codes and player states for the song sequencer
package song_pkg;
  localparam logic [7:0] NOTE_REST = 8'd255;
  localparam logic [7:0] NOTE_END = 8'd1;
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, PLAY, DONE} state_t;
endpackage

// File: rtl/song_sequencer_if.sv
// song_sequencer_if: control, note ROM and tone-generator signals of the sequencer
interface song_sequencer_if #(
  parameter int ADDR_W = 9,
  parameter int TEMPO_W = 24
);
  logic start, stop, loop;
  logic [TEMPO_W-1:0] tempo;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0] rom_note, note;
  logic gate, note_on, playing, done;
  modport master(
    input start, stop, loop, tempo, rom_note,
    output rom_addr, note, gate, note_on, playing, done
  );
  modport slave(
    output start, stop, loop, tempo, rom_note,
    input rom_addr, note, gate, note_on, playing, done
  );
endinterface

// File: rtl/song_sequencer_step_timer.sv
// step_timer: per-step clock counter with end-of-step and gate-release compares
module step_timer #(
  parameter int TEMPO_W = 24,
  parameter int ARTIC = 16
) (
  input logic clk,
  input logic reset,
  input logic load,
  input logic en,
  input logic [TEMPO_W-1:0] len,
  output logic term,
  output logic artic
);
  logic [TEMPO_W-1:0] step_len, cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      step_len <= '0;
      cnt <= '0;
    end else if (load) begin
      step_len <= len;
      cnt <= '0;
    end else if (en && !term) cnt <= cnt + 1'b1;
  assign term = cnt == step_len;
  // true on the edge before the last ARTIC clocks of the step, so gate is low for exactly those
  assign artic = {1'b0, cnt} + (TEMPO_W+1)'(ARTIC) >= {1'b0, step_len};
endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: walks an external note ROM and drives note/gate/note_on with tempo, loop and articulation
module song_sequencer
  import song_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int TEMPO_W = 24,
  parameter int ARTIC = 16
) (
  input logic clk,
  input logic reset,
  song_sequencer_if.master s
);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0] note_n;
  logic gate_n, note_on_n, load, term, artic;
  step_timer #(.TEMPO_W(TEMPO_W), .ARTIC(ARTIC)) u_timer (
    .clk(clk),
    .reset(reset),
    .load(load),
    .en(state == PLAY),
    .len(s.tempo),
    .term(term),
    .artic(artic)
  );
  always_comb begin
    state_n = state;
    addr_n = s.rom_addr;
    note_n = s.note;
    gate_n = s.gate;
    note_on_n = 1'b0;
    load = 1'b0;
    if (s.stop && state != IDLE) begin
      state_n = IDLE;
      addr_n = '0;
      gate_n = 1'b0;
    end else
      unique case (state)
        IDLE, DONE:
          if (s.start) begin
            state_n = FETCH;
            addr_n = '0;
          end
        FETCH: state_n = LATCH;
        LATCH: begin
          load = 1'b1;
          if (s.rom_note == NOTE_END) begin
            state_n = s.loop ? FETCH : DONE;
            gate_n = 1'b0;
            if (s.loop) addr_n = '0;
          end else begin
            state_n = PLAY;
            gate_n = s.rom_note != NOTE_REST;
            note_on_n = s.rom_note != NOTE_REST;
            note_n = s.rom_note != NOTE_REST ? s.rom_note : s.note;
          end
        end
        PLAY: begin
          if (artic) gate_n = 1'b0;
          // address increment wraps to 0 by itself; only the non-loop wrap stops playback
          if (term) begin
            addr_n = s.rom_addr + 1'b1;
            state_n = (&s.rom_addr && !s.loop) ? DONE : FETCH;
          end
        end
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      s.rom_addr <= '0;
      s.note <= NOTE_REST;
      s.gate <= 1'b0;
      s.note_on <= 1'b0;
    end else begin
      state <= state_n;
      s.rom_addr <= addr_n;
      s.note <= note_n;
      s.gate <= gate_n;
      s.note_on <= note_on_n;
    end
  assign s.playing = state == FETCH || state == LATCH || state == PLAY;
  assign s.done = state == DONE;
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: scoreboard bench comparing note_on timing, pitch, gate time and end state with a step-level model
module tb_song_sequencer;
  localparam int AW = 3;
  localparam int TW = 8;
  localparam int ART = 2;
  localparam int LAST = (1 << AW) - 1;
  typedef struct {
    int cyc;
    int note;
  } ev_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0, n_pass = 0, n_total = 0, gate_cnt = 0, base = 0, exp_done = -1, exp_g = 0;
  logic [7:0] rom[LAST+1];
  ev_t q[$];
  ev_t mon_e;
  song_sequencer_if #(.ADDR_W(AW), .TEMPO_W(TW)) s ();
  song_sequencer #(.ADDR_W(AW), .TEMPO_W(TW), .ARTIC(ART)) dut (
    .clk(clk),
    .reset(reset),
    .s(s)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) s.rom_note <= rom[s.rom_addr];
  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask
  always @(negedge clk) begin
    if (s.gate) gate_cnt++;
    if (s.note_on) begin
      if (q.size() == 0) chk("unexpected_note_on", q.size(), 1);
      else begin
        mon_e = q.pop_front();
        chk("note_on_cycle", cyc, mon_e.cyc);
        chk("note_value", int'(s.note), mon_e.note);
      end
    end
  end
  // Step-level model: every step costs FETCH+LATCH (2) and sounding/rest steps add tempo+1 of PLAY
  task automatic kick(input bit lp, input int ta, input int tb_, input int chg, input int lim);
    ev_t ev[$];
    int t = 0, a = 0, tp, h, v;
    exp_done = -1;
    exp_g = 0;
    for (int it = 0; it < 4000; it++) begin
      if (lim > 0 && t >= lim) break;
      v = int'(rom[a]);
      if (v == 1) begin
        if (!lp) begin
          exp_done = t + 2;
          break;
        end
        t += 2;
        a = 0;
        continue;
      end
      tp = (chg > 0 && t + 2 >= chg) ? tb_ : ta;
      if (v != 255 && (lim == 0 || t + 2 < lim)) begin
        ev.push_back('{cyc: t + 2, note: v});
        h = (tp + 1 - ART > 1) ? tp + 1 - ART : 1;
        for (int k = t + 2; k < t + 2 + h; k++) if (lim == 0 || k < lim) exp_g++;
      end
      t += tp + 3;
      if (a == LAST) begin
        if (!lp) begin
          exp_done = t;
          break;
        end
        a = 0;
      end else a++;
    end
    s.loop = lp;
    s.tempo = TW'(ta);
    @(negedge clk);
    s.start = 1'b1;
    @(posedge clk);
    #1 s.start = 1'b0;
    base = cyc;
    gate_cnt = 0;
    foreach (ev[i]) q.push_back('{cyc: ev[i].cyc + base, note: ev[i].note});
  endtask
  task automatic run(input bit lp, input int ta, input int tb_, input int chg, input int stop_at, input bit both);
    kick(lp, ta, tb_, chg, stop_at);
    if (chg > 0) begin
      repeat (chg) @(negedge clk);
      s.tempo = TW'(tb_);
    end
    if (stop_at > 0) begin
      repeat (stop_at - chg) @(negedge clk);
      s.stop = 1'b1;
      s.start = both;
      @(posedge clk);
      #1 s.stop = 1'b0;
      s.start = 1'b0;
      chk("stop_playing", int'(s.playing), 0);
      chk("stop_gate", int'(s.gate), 0);
      chk("stop_rom_addr", int'(s.rom_addr), 0);
      chk("stop_done", int'(s.done), 0);
    end else begin
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (s.done) break;
      end
      #1 chk("done_cycle", cyc, base + exp_done);
      chk("done_playing", int'(s.playing), 0);
    end
    chk("queue_drained", q.size(), 0);
    chk("gate_clocks", gate_cnt, exp_g);
    q.delete();
  endtask
  initial begin
    #1000000 $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    int r, p, ta, tb_, chg, st;
    bit lp;
    s.start = 1'b0;
    s.stop = 1'b0;
    s.loop = 1'b0;
    s.tempo = '0;
    foreach (rom[i]) rom[i] = 8'd1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1 chk("reset_note", int'(s.note), 255);
    chk("reset_gate", int'(s.gate), 0);
    chk("reset_note_on", int'(s.note_on), 0);
    chk("reset_playing", int'(s.playing), 0);
    chk("reset_done", int'(s.done), 0);
    chk("reset_rom_addr", int'(s.rom_addr), 0);
    rom[0] = 8'd66; rom[1] = 8'd66; rom[2] = 8'd255; rom[3] = 8'd71; rom[4] = 8'd1;
    run(0, 9, 9, 0, 0, 0);
    run(1, 9, 9, 0, 120, 0);
    foreach (rom[i]) rom[i] = 8'(60 + 2 * i);
    run(0, 4, 4, 0, 0, 0);
    run(1, 2, 2, 0, 90, 0);
    rom[3] = 8'd1;
    run(0, 9, 3, 6, 0, 0);
    rom[0] = 8'd66; rom[1] = 8'd66; rom[2] = 8'd255; rom[3] = 8'd71; rom[4] = 8'd1;
    run(1, 9, 9, 0, 20, 1);
    repeat (5) @(negedge clk);
    chk("stop_start_idle", int'(s.playing), 0);
    chk("stop_start_addr", int'(s.rom_addr), 0);
    repeat (14) begin
      foreach (rom[i]) begin
        r = $urandom_range(0, 9);
        p = $urandom_range(0, 254);
        if (p == 1) p = 0;
        rom[i] = r < 2 ? 8'd255 : r < 3 ? 8'd1 : 8'(p);
      end
      lp = 1'($urandom_range(0, 1));
      ta = $urandom_range(0, 15);
      tb_ = $urandom_range(0, 15);
      chg = lp && $urandom_range(0, 1) ? $urandom_range(1, 20) : 0;
      st = lp ? $urandom_range(25, 150) : 0;
      run(lp, ta, lp ? tb_ : ta, chg, st, 0);
    end
    foreach (rom[i]) rom[i] = 8'd255;
    rom[0] = 8'd70;
    kick(1, 20, 20, 0, 9);
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("async_reset_note", int'(s.note), 255);
    chk("async_reset_gate", int'(s.gate), 0);
    chk("async_reset_playing", int'(s.playing), 0);
    chk("async_reset_queue", q.size(), 0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", int'(s.playing), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
